fir_frame_sequencer: RTL and testbench

Frame-level controller that sequences the N-tap FIR filter datapath. It accepts sample frames over a valid/ready stream, clears the filter delay line at frame start, and feeds samples into the filter back-to-back. At frame end it injects TAPS-1 zero samples to flush the tail, so each frame yields its full convolution. It tags the filter output with valid/last flags aligned to the filter latency, and sits between the upstream sample source and the filter instance.

---
 rtl/fir_frame_sequencer_if.sv | 23 ++
 rtl/fir_frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_fir_frame_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_frame_sequencer_if.sv
// Stream bundle for the FIR frame sequencer: upstream sample handshake plus tagged output.
// Input handshake: a sample transfers on a rising clk edge where s_valid & s_ready; s_last is qualified by it.
interface fir_frame_sequencer_if #(
  parameter int DW = 16
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fir_frame_sequencer.sv
// Frame controller for an N-tap FIR: clears the delay line per frame, streams samples,
// flushes the tail with TAPS-1 zeros and tags filter outputs with valid/last.
module fir_frame_sequencer #(
  parameter int TAPS = 8,
  parameter int DW   = 16,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_frame_sequencer_if.slave bus,
  output logic                 fir_rst,
  output logic [DW-1:0]        fir_data_in,
  input  logic [DW-1:0]        fir_data_out,
  output logic                 busy,
  output logic                 err_underrun,
  output logic [15:0]          frame_cnt,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam int FCW = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'((TAPS >= 2) ? TAPS - 2 : 0);

  state_t          state, state_n;
  logic [FCW-1:0]  flush_cnt;
  logic [LAT:0]    tag_v;
  logic [LAT:0]    tag_l;

  logic            s_ready;
  logic            hs;
  logic            issue;
  logic [DW-1:0]   issue_data;
  logic            issue_last;
  logic            load_flush;
  logic            dec_flush;
  logic            set_err;
  logic            clear_err;
  logic            done;
  logic            m_valid;
  logic            m_last;

  assign hs = bus.s_valid & s_ready;

  always_comb begin
    state_n    = state;
    s_ready    = 1'b0;
    issue      = 1'b0;
    issue_data = '0;
    issue_last = 1'b0;
    load_flush = 1'b0;
    dec_flush  = 1'b0;
    set_err    = 1'b0;
    clear_err  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_valid) state_n = CLEAR;
      end
      CLEAR: begin
        clear_err = 1'b1;
        state_n   = STREAM;
      end
      STREAM: begin
        // A cycle without a handshake still issues a zero: the filter has no enable.
        s_ready = 1'b1;
        issue   = 1'b1;
        if (hs) begin
          issue_data = bus.s_data;
          if (bus.s_last) begin
            if (TAPS == 1) begin
              issue_last = 1'b1;
              state_n    = DRAIN;
            end else begin
              load_flush = 1'b1;
              state_n    = FLUSH;
            end
          end
        end else begin
          set_err = 1'b1;
        end
      end
      FLUSH: begin
        issue     = 1'b1;
        dec_flush = 1'b1;
        if (flush_cnt == '0) begin
          issue_last = 1'b1;
          state_n    = DRAIN;
        end
      end
      DRAIN: begin
        if (m_last) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fir_data_in  <= '0;
      flush_cnt    <= '0;
      err_underrun <= 1'b0;
      frame_cnt    <= '0;
      tag_v        <= '0;
      tag_l        <= '0;
    end else begin
      state       <= state_n;
      fir_data_in <= issue ? issue_data : '0;
      if (load_flush) flush_cnt <= FLUSH_INIT;
      else if (dec_flush && flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
      if (clear_err) err_underrun <= 1'b0;
      else if (set_err) err_underrun <= 1'b1;
      if (done) frame_cnt <= frame_cnt + 16'd1;
      // Tag stage 0 lines up with fir_data_in; stage LAT lines up with fir_data_out.
      tag_v <= {tag_v[LAT-1:0], issue};
      tag_l <= {tag_l[LAT-1:0], issue_last};
    end
  end

  assign m_valid     = tag_v[LAT];
  assign m_last      = tag_v[LAT] & tag_l[LAT];
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_last  = m_last;
  assign bus.m_data  = m_valid ? fir_data_out : '0;
  assign fir_rst     = rst | (state == CLEAR);
  assign busy        = (state != IDLE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Randomized scoreboard bench: a behavioural FIR sits behind the sequencer, and expected
// outputs come from a per-frame convolution of the issued sample sequence.
module tb_fir_frame_sequencer;

  localparam int TAPS = 8;
  localparam int DW   = 16;
  localparam int LAT  = 1;
  localparam int H [0:TAPS-1] = '{3, 1, 4, 1, 5, 9, 2, 6};
  localparam int H1 = 3;
  localparam logic [2:0] ST_FLUSH = 3'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance, TAPS=8 ----------------
  fir_frame_sequencer_if #(.DW(DW)) u_if ();
  logic          fir_rst;
  logic [DW-1:0] fir_data_in;
  logic [DW-1:0] fir_data_out;
  logic          busy;
  logic          err_underrun;
  logic [15:0]   frame_cnt;
  logic [2:0]    dbg_state;

  fir_frame_sequencer #(.TAPS(TAPS), .DW(DW), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (u_if.slave),
    .fir_rst      (fir_rst),
    .fir_data_in  (fir_data_in),
    .fir_data_out (fir_data_out),
    .busy         (busy),
    .err_underrun (err_underrun),
    .frame_cnt    (frame_cnt),
    .dbg_state    (dbg_state)
  );

  // Behavioural filter, latency 1: dl[j] holds the input from j+1 cycles ago.
  logic [DW-1:0] dl [0:TAPS-2];
  int            acc;
  always_comb begin
    acc = H[0] * int'(fir_data_in);
    for (int j = 1; j < TAPS; j++) acc = acc + H[j] * int'(dl[j-1]);
  end
  always @(posedge clk) begin
    if (fir_rst) begin
      for (int j = 0; j < TAPS - 1; j++) dl[j] <= '0;
      fir_data_out <= '0;
    end else begin
      dl[0] <= fir_data_in;
      for (int j = 1; j < TAPS - 1; j++) dl[j] <= dl[j-1];
      fir_data_out <= acc[DW-1:0];
    end
  end

  // ---------------- second instance, TAPS=1 ----------------
  fir_frame_sequencer_if #(.DW(DW)) u_if1 ();
  logic          fir_rst1;
  logic [DW-1:0] fir_data_in1;
  logic [DW-1:0] fir_data_out1;
  logic          busy1;
  logic          err_underrun1;
  logic [15:0]   frame_cnt1;
  logic [2:0]    dbg_state1;

  fir_frame_sequencer #(.TAPS(1), .DW(DW), .LAT(LAT)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .bus          (u_if1.slave),
    .fir_rst      (fir_rst1),
    .fir_data_in  (fir_data_in1),
    .fir_data_out (fir_data_out1),
    .busy         (busy1),
    .err_underrun (err_underrun1),
    .frame_cnt    (frame_cnt1),
    .dbg_state    (dbg_state1)
  );

  int acc1;
  assign acc1 = H1 * int'(fir_data_in1);
  always @(posedge clk) begin
    if (fir_rst1) fir_data_out1 <= '0;
    else          fir_data_out1 <= acc1[DW-1:0];
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_q [$];
  logic [DW:0] exp1_q [$];
  int   hist [$];
  int   first_hs_cyc = 0;
  int   frame_pos = 0;
  bit   busy_chk = 1'b0;
  bit   had_gap = 1'b0;
  int   frame_exp = 0;
  bit   flush_seen1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full convolution output n of the current frame's issued samples.
  function automatic int conv(input int n);
    int s = 0;
    for (int j = 0; j < TAPS; j++) begin
      int k = n - j;
      if (k >= 0 && k < hist.size()) s += H[j] * hist[k];
    end
    return s;
  endfunction

  task automatic slot(input int v);
    int y;
    hist.push_back(v);
    y = conv(hist.size() - 1);
    exp_q.push_back({1'b0, y[DW-1:0]});
  endtask

  task automatic finish_frame();
    int len = hist.size();
    for (int n = len; n <= len + TAPS - 2; n++) begin
      int y = conv(n);
      exp_q.push_back({(n == len + TAPS - 2), y[DW-1:0]});
    end
    hist.delete();
    frame_exp++;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [DW:0] e;
    if (busy_chk) begin
      chk("busy_after_last", busy, 0);
      busy_chk = 1'b0;
    end
    if (u_if.m_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_m_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", u_if.m_data, e[DW-1:0]);
        chk("m_last", u_if.m_last, e[DW]);
        if (frame_pos == 0) chk("first_out_latency", cyc - first_hs_cyc, 1 + LAT);
        frame_pos++;
        if (e[DW]) begin
          frame_pos = 0;
          chk("busy_at_last", busy, 1);
          busy_chk = 1'b1;
        end
      end
    end else begin
      chk("m_data_idle", u_if.m_data, 0);
      chk("m_last_idle", u_if.m_last, 0);
    end
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    if (dbg_state1 == ST_FLUSH) flush_seen1 = 1'b1;
    if (u_if1.m_valid) begin
      if (exp1_q.size() == 0) begin
        chk("t1_unexpected_m_valid", 1, 0);
      end else begin
        e = exp1_q.pop_front();
        chk("t1_m_data", u_if1.m_data, e[DW-1:0]);
        chk("t1_m_last", u_if1.m_last, e[DW]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int d, input logic last);
    int n = 0;
    u_if.s_valid = 1'b1;
    u_if.s_data  = d[DW-1:0];
    u_if.s_last  = last;
    while (!u_if.s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("handshake_timeout", 1, 0);
    @(posedge clk); #1;
    if (hist.size() == 0) begin
      first_hs_cyc = cyc - 1;
      had_gap = 1'b0;
      chk("err_clear_at_start", err_underrun, 0);
    end
    slot(d);
    if (last) finish_frame();
  endtask

  task automatic gap();
    u_if.s_valid = 1'b0;
    @(posedge clk); #1;
    slot(0);
    had_gap = 1'b1;
    chk("err_after_gap", err_underrun, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    u_if.s_valid = 1'b0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("idle_timeout", 1, 0);
    @(posedge clk); #1;
    chk("frame_cnt", frame_cnt, frame_exp);
    chk("err_end_of_frame", err_underrun, had_gap);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len;
    u_if.s_valid  = 1'b0;
    u_if.s_data   = '0;
    u_if.s_last   = 1'b0;
    u_if1.s_valid = 1'b0;
    u_if1.s_data  = '0;
    u_if1.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", u_if.s_ready, 0);
    chk("rst_m_valid", u_if.m_valid, 0);
    chk("rst_fir_data_in", fir_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_fir_rst", fir_rst, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Impulse, then a two-sample frame, then a frame with a gap.
    send(1, 1'b1);
    wait_idle();
    send(1, 1'b0);
    send(2, 1'b1);
    wait_idle();
    send(1, 1'b0);
    gap();
    send(2, 1'b1);
    wait_idle();

    // Back-to-back frames with s_valid held between them.
    send(3, 1'b1);
    send(5, 1'b1);
    wait_idle();

    repeat (25) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) gap();
        send($urandom_range(0, 20), (i == len - 1));
      end
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    // Reset held for three cycles in the middle of a frame.
    send(4, 1'b0);
    send(6, 1'b0);
    rst = 1'b1;
    u_if.s_valid = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    hist.delete();
    frame_pos = 0;
    busy_chk  = 1'b0;
    frame_exp = 0;
    had_gap   = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_ready", u_if.s_ready, 0);
    chk("mid_rst_m_valid", u_if.m_valid, 0);
    chk("mid_rst_m_last", u_if.m_last, 0);
    chk("mid_rst_m_data", u_if.m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_underrun, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_fir_rst", fir_rst, 1);
    chk("mid_rst_fir_data_in", fir_data_in, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_rst", busy, 0);
    send(2, 1'b0);
    send(7, 1'b1);
    wait_idle();

    // TAPS=1 instance: frame {7,9}.
    begin
      int n = 0;
      flush_seen1 = 1'b0;
      u_if1.s_valid = 1'b1;
      u_if1.s_data  = 16'd7;
      u_if1.s_last  = 1'b0;
      while (!u_if1.s_ready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) chk("t1_handshake_timeout", 1, 0);
      @(posedge clk); #1;
      exp1_q.push_back({1'b0, 16'(H1 * 7)});
      u_if1.s_data = 16'd9;
      u_if1.s_last = 1'b1;
      @(posedge clk); #1;
      exp1_q.push_back({1'b1, 16'(H1 * 9)});
      u_if1.s_valid = 1'b0;
      n = 0;
      while (busy1 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) chk("t1_idle_timeout", 1, 0);
      @(posedge clk); #1;
      chk("t1_frame_cnt", frame_cnt1, 1);
      chk("t1_no_flush", flush_seen1, 0);
      chk("t1_queue_drained", exp1_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d want %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
